fp_add_pipe: RTL

//  Parametrised, 3-stage pipelined sign-magnitude float adder/subtractor. Next generation of the

---
 rtl/fp_pkg.sv | 22 ++
 rtl/fp_norm.sv | 58 +++++
 rtl/fp_add_pipe.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared float format defaults, word type and helpers
package fp_pkg;

    localparam int DEF_EXP_W  = 3;
    localparam int DEF_FRAC_W = 4;
    localparam int DEF_GRD_W  = 5;

    typedef struct packed {
        logic                  s;
        logic [DEF_EXP_W-1:0]  e;
        logic [DEF_FRAC_W-1:0] f;
    } fp_t;

    localparam fp_t FP_ZERO = '{s: 1'b0, e: '0, f: '0};
    localparam fp_t FP_MAX  = '{s: 1'b0, e: '1, f: '1};

    // Zero is encoded by magnitude alone; the sign bit is ignored
    function automatic logic is_zero(input fp_t v);
        return ({v.e, v.f} == '0);
    endfunction

endpackage

// File: rtl/fp_norm.sv
// rtl/fp_norm.sv - leading-one normalise, exponent adjust, saturate/flush and pack
module fp_norm #(
    parameter  int EXP_W  = 3,
    parameter  int FRAC_W = 4,
    parameter  int GRD_W  = 5,
    localparam int MW     = FRAC_W + GRD_W + 1,
    localparam int W      = 1 + EXP_W + FRAC_W
) (
    input  logic [MW:0]      sum,
    input  logic [EXP_W-1:0] e,
    input  logic             s,
    output logic [W-1:0]     z,
    output logic             ovf,
    output logic             unf
);

    localparam int LZW = $clog2(MW);

    logic [LZW-1:0]    lz;
    logic              found;
    logic [MW-2:0]     shifted;
    logic [FRAC_W-1:0] frac_n;

    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = LZW'(MW - 1 - i);
                found = 1'b1;
            end
        end
        // Bit MW-1 is zero whenever lz > 0, so the bits under the leading one come from the low part
        shifted = sum[MW-2:0] << lz;
        frac_n  = FRAC_W'(shifted >> (MW - 1 - FRAC_W));
    end

    always_comb begin
        z   = '0;
        ovf = 1'b0;
        unf = 1'b0;
        if (|sum) begin
            if (sum[MW]) begin
                if (e == '1) begin
                    z   = {s, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
                    ovf = 1'b1;
                end else begin
                    z = {s, e + EXP_W'(1), sum[MW-1 -: FRAC_W]};
                end
            end else if (int'(lz) > int'(e)) begin
                unf = 1'b1;
            end else begin
                z = {s, EXP_W'(int'(e) - int'(lz)), frac_n};
            end
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - 3-stage pipelined sign-magnitude float adder/subtractor
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W  = DEF_EXP_W,
    parameter  int FRAC_W = DEF_FRAC_W,
    parameter  int GRD_W  = DEF_GRD_W,
    localparam int W      = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op_sub,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z,
    output logic         ovf,
    output logic         unf
);

    localparam int MW = FRAC_W + GRD_W + 1;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // S1: unpack, zero bypass, order by magnitude, align the smaller mantissa
    logic              ys, x_big, byp_n, sub_n, sb_n;
    logic [W-2:0]      mx, my;
    logic [W-1:0]      bz_n;
    logic [EXP_W-1:0]  eb, es, shift;
    logic [FRAC_W-1:0] fb, fs;
    logic [MW-1:0]     mb_n, ms_n;

    always_comb begin
        ys    = y[W-1] ^ op_sub;
        mx    = x[W-2:0];
        my    = y[W-2:0];
        byp_n = (mx == '0) || (my == '0);
        bz_n  = '0;
        if (mx != '0 && my == '0)
            bz_n = x;
        else if (mx == '0 && my != '0)
            bz_n = {ys, my};
        x_big = mx > my;
        sb_n  = x_big ? x[W-1] : ys;
        eb    = x_big ? x[W-2 -: EXP_W] : y[W-2 -: EXP_W];
        es    = x_big ? y[W-2 -: EXP_W] : x[W-2 -: EXP_W];
        fb    = x_big ? x[FRAC_W-1:0] : y[FRAC_W-1:0];
        fs    = x_big ? y[FRAC_W-1:0] : x[FRAC_W-1:0];
        shift = eb - es;
        mb_n  = {1'b1, fb, {GRD_W{1'b0}}};
        ms_n  = {1'b1, fs, {GRD_W{1'b0}}};
        if (int'(shift) >= MW)
            ms_n = '0;
        else
            ms_n = ms_n >> shift;
        sub_n = x[W-1] ^ ys;
    end

    logic             v1, byp1, s1, sub1;
    logic [W-1:0]     bz1;
    logic [EXP_W-1:0] e1;
    logic [MW-1:0]    mb1, ms1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            byp1 <= 1'b0;
            s1   <= 1'b0;
            sub1 <= 1'b0;
            bz1  <= '0;
            e1   <= '0;
            mb1  <= '0;
            ms1  <= '0;
        end else if (adv) begin
            v1   <= in_valid;
            byp1 <= byp_n;
            s1   <= sb_n;
            sub1 <= sub_n;
            bz1  <= bz_n;
            e1   <= eb;
            mb1  <= mb_n;
            ms1  <= ms_n;
        end
    end

    // S2: magnitude add/subtract; Big >= Small so the difference never goes negative
    logic [MW:0] sum_n;
    assign sum_n = sub1 ? ({1'b0, mb1} - {1'b0, ms1}) : ({1'b0, mb1} + {1'b0, ms1});

    logic             v2, byp2, s2;
    logic [W-1:0]     bz2;
    logic [EXP_W-1:0] e2;
    logic [MW:0]      sum2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            byp2 <= 1'b0;
            s2   <= 1'b0;
            bz2  <= '0;
            e2   <= '0;
            sum2 <= '0;
        end else if (adv) begin
            v2   <= v1;
            byp2 <= byp1;
            s2   <= s1;
            bz2  <= bz1;
            e2   <= e1;
            sum2 <= sum_n;
        end
    end

    // S3: normalise and pack
    logic [W-1:0] nz;
    logic         novf, nunf;

    fp_norm #(
        .EXP_W (EXP_W),
        .FRAC_W(FRAC_W),
        .GRD_W (GRD_W)
    ) u_norm (
        .sum(sum2),
        .e  (e2),
        .s  (s2),
        .z  (nz),
        .ovf(novf),
        .unf(nunf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            z         <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (adv) begin
            out_valid <= v2;
            z         <= byp2 ? bz2 : nz;
            ovf       <= v2 && !byp2 && novf;
            unf       <= v2 && !byp2 && nunf;
        end
    end

endmodule
